// File: rtl/atm_txn_controller_pkg.sv
// Shared types and default sizes for the ATM transaction controller.
package atm_pkg;

    localparam int ATM_W          = 10;   // amount / balance width
    localparam int ATM_ACC_AW     = 4;    // account address width
    localparam int ATM_LOCK_LIMIT = 3;    // consecutive rejects before lockout

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_LOAD   = 3'd2,
        S_CHECK  = 3'd3,
        S_COMMIT = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_DEP  = 2'd1,
        OP_WD   = 2'd2
    } op_t;

    // Exactly one of deposit/withdraw makes a legal request; anything else is OP_NONE.
    function automatic op_t decode_op(input logic dep, input logic wd);
        case ({dep, wd})
            2'b10:   return OP_DEP;
            2'b01:   return OP_WD;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/atm_txn_controller_if.sv
// Bundle of request, account-memory, parser and status signals around the controller.
// master = controller side, slave = front end / memory / parser side.
interface atm_txn_controller_if #(
    parameter int W      = atm_pkg::ATM_W,
    parameter int ACC_AW = atm_pkg::ATM_ACC_AW
) ();
    // front-end request
    logic              start;
    logic              op_deposit;
    logic              op_withdraw;
    logic [ACC_AW-1:0] acct_id;
    logic [W-1:0]      amount_in;
    logic              session_end;
    // account memory
    logic [ACC_AW-1:0] mem_addr;
    logic              mem_re;
    logic [W-1:0]      mem_rdata;
    logic              mem_we;
    logic [W-1:0]      mem_wdata;
    // amount parser
    logic              deposite;
    logic              withdraw;
    logic              balance_update;
    logic [W-1:0]      amount_user;
    logic [W-1:0]      amount_account;
    logic              valid_transaction;
    logic              amount_entered_sucessfully;
    logic [W-1:0]      newBalance;
    // status
    logic              busy;
    logic              done;
    logic              accepted;
    logic              rejected;
    logic [W-1:0]      balance_out;
    logic              locked;

    modport master (
        input  start, op_deposit, op_withdraw, acct_id, amount_in, session_end,
        input  mem_rdata, valid_transaction, amount_entered_sucessfully, newBalance,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output deposite, withdraw, balance_update, amount_user, amount_account,
        output busy, done, accepted, rejected, balance_out, locked
    );

    modport slave (
        output start, op_deposit, op_withdraw, acct_id, amount_in, session_end,
        output mem_rdata, valid_transaction, amount_entered_sucessfully, newBalance,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  deposite, withdraw, balance_update, amount_user, amount_account,
        input  busy, done, accepted, rejected, balance_out, locked
    );

endinterface

// File: rtl/atm_txn_controller_lockout.sv
// Consecutive-reject counter with saturating lockout flag.
module txn_lockout
    import atm_pkg::*;
#(
    parameter int LOCK_LIMIT = ATM_LOCK_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,          // one reject completed
    input  logic i_clr,          // one accept completed
    input  logic i_session_end,  // card removed (already qualified to IDLE)
    output logic o_locked
);

    localparam logic [2:0] LIMIT = 3'(LOCK_LIMIT);

    logic [2:0] r_rej_cnt;

    // Count rejects, saturating at the limit; any accept or session end starts over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rej_cnt <= 3'd0;
        end else if (i_clr || i_session_end) begin
            r_rej_cnt <= 3'd0;
        end else if (i_inc && (r_rej_cnt != LIMIT)) begin
            r_rej_cnt <= r_rej_cnt + 3'd1;
        end
    end

    assign o_locked = (r_rej_cnt == LIMIT);

endmodule

// File: rtl/atm_txn_controller.sv
// Sequences one ATM transaction: latch request, read balance, drive the amount
// parser, write the parser's new balance back and report accept/reject.
module atm_txn_controller
    import atm_pkg::*;
#(
    parameter int W          = ATM_W,
    parameter int ACC_AW     = ATM_ACC_AW,
    parameter int LOCK_LIMIT = ATM_LOCK_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    atm_txn_controller_if.master  bus
);

    state_t            r_state;
    op_t               r_op;
    logic [ACC_AW-1:0] r_acct;
    logic [W-1:0]      r_amount;
    logic [W-1:0]      r_bal;
    logic [W-1:0]      r_nb;

    // registered outputs
    logic              r_busy;
    logic              r_done;
    logic              r_accepted;
    logic              r_rejected;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [ACC_AW-1:0] r_mem_addr;
    logic [W-1:0]      r_mem_wdata;
    logic              r_deposite;
    logic              r_withdraw;
    logic              r_balance_update;
    logic [W-1:0]      r_amount_user;
    logic [W-1:0]      r_amount_account;
    logic [W-1:0]      r_balance_out;

    logic w_locked;
    logic w_idle;
    logic w_session_clr;
    logic w_start_ok;
    logic w_legal;
    logic w_accept;
    logic w_rej_inc;
    logic w_acc_clr;
    op_t  w_req_op;

    assign w_idle        = (r_state == S_IDLE);
    assign w_req_op      = decode_op(bus.op_deposit, bus.op_withdraw);
    assign w_legal       = (w_req_op != OP_NONE);
    // session_end only matters in IDLE, and there it takes priority over start
    assign w_session_clr = w_idle && bus.session_end;
    assign w_start_ok    = w_idle && bus.start && !w_locked && !bus.session_end;
    assign w_accept      = bus.valid_transaction && bus.amount_entered_sucessfully;
    // an illegal op and a parser refusal are both rejects
    assign w_rej_inc     = (w_start_ok && !w_legal) || ((r_state == S_CHECK) && !w_accept);
    assign w_acc_clr     = (r_state == S_WRITE);

    txn_lockout #(
        .LOCK_LIMIT (LOCK_LIMIT)
    ) u_lockout (
        .clk           (clk),
        .rst           (rst),
        .i_inc         (w_rej_inc),
        .i_clr         (w_acc_clr),
        .i_session_end (w_session_clr),
        .o_locked      (w_locked)
    );

    // Transaction FSM with request latches; outputs are registered alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_op             <= OP_NONE;
            r_acct           <= '0;
            r_amount         <= '0;
            r_bal            <= '0;
            r_nb             <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_accepted       <= 1'b0;
            r_rejected       <= 1'b0;
            r_mem_re         <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_deposite       <= 1'b0;
            r_withdraw       <= 1'b0;
            r_balance_update <= 1'b0;
            r_amount_user    <= '0;
            r_amount_account <= '0;
            r_balance_out    <= '0;
        end else begin
            // strobes and parser drive are active only in the states that set them
            r_done           <= 1'b0;
            r_accepted       <= 1'b0;
            r_rejected       <= 1'b0;
            r_mem_re         <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_wdata      <= '0;
            r_deposite       <= 1'b0;
            r_withdraw       <= 1'b0;
            r_balance_update <= 1'b0;
            r_amount_user    <= '0;
            r_amount_account <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_op       <= w_req_op;
                        r_acct     <= bus.acct_id;
                        r_amount   <= bus.amount_in;
                        r_mem_addr <= bus.acct_id;
                        r_busy     <= 1'b1;
                        if (w_legal) begin
                            r_state  <= S_READ;
                            r_mem_re <= 1'b1;
                        end else begin
                            // illegal op: no memory access, report a zero balance
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_rejected    <= 1'b1;
                            r_balance_out <= '0;
                        end
                    end
                end

                S_READ: begin
                    // read data appears on mem_rdata during LOAD
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_state          <= S_CHECK;
                    r_bal            <= bus.mem_rdata;
                    r_deposite       <= (r_op == OP_DEP);
                    r_withdraw       <= (r_op == OP_WD);
                    r_amount_user    <= r_amount;
                    r_amount_account <= bus.mem_rdata;
                end

                S_CHECK: begin
                    if (w_accept) begin
                        r_state          <= S_COMMIT;
                        r_deposite       <= (r_op == OP_DEP);
                        r_withdraw       <= (r_op == OP_WD);
                        r_balance_update <= 1'b1;
                        r_amount_user    <= r_amount;
                        r_amount_account <= r_bal;
                    end else begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_rejected    <= 1'b1;
                        r_balance_out <= r_bal;
                    end
                end

                S_COMMIT: begin
                    // newBalance is only valid while balance_update is high, so grab it now
                    r_state     <= S_WRITE;
                    r_nb        <= bus.newBalance;
                    r_mem_we    <= 1'b1;
                    r_mem_wdata <= bus.newBalance;
                    r_mem_addr  <= r_acct;
                end

                S_WRITE: begin
                    r_state       <= S_DONE;
                    r_done        <= 1'b1;
                    r_accepted    <= 1'b1;
                    r_balance_out <= r_nb;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.accepted       = r_accepted;
    assign bus.rejected       = r_rejected;
    assign bus.mem_re         = r_mem_re;
    // a reset landing on the WRITE cycle must keep the memory untouched
    assign bus.mem_we         = r_mem_we & ~rst;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.deposite       = r_deposite;
    assign bus.withdraw       = r_withdraw;
    assign bus.balance_update = r_balance_update;
    assign bus.amount_user    = r_amount_user;
    assign bus.amount_account = r_amount_account;
    assign bus.balance_out    = r_balance_out;
    assign bus.locked         = w_locked;

endmodule

// File: tb/tb_atm_txn_controller.sv
// Bench for atm_txn_controller: account memory and amount parser stand-ins,
// a transaction-level expectation model, directed scenarios and random traffic.
module tb_atm_txn_controller;

    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    atm_txn_controller_if #(.W(10), .ACC_AW(4)) bus ();

    atm_txn_controller #(.W(10), .ACC_AW(4), .LOCK_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- environment: account memory ----------------
    logic [9:0] env_mem [16];
    logic [9:0] rdata_r;
    logic       preload = 1'b1;

    function automatic logic [9:0] init_val(input int i);
        case (i)
            0: return 10'd200;
            1: return 10'd0;
            2: return 10'd1000;
            3: return 10'd500;
            4: return 10'd200;
            5: return 10'd1000;
            default: return 10'((i * 97 + 13) % 1000);
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        end else begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_re) rdata_r <= env_mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata_r;

    // ---------------- environment: amount parser ----------------
    assign bus.valid_transaction = bus.deposite ^ bus.withdraw;
    assign bus.amount_entered_sucessfully = bus.deposite ?
        (({1'b0, bus.amount_user} + {1'b0, bus.amount_account}) <= 11'd1023) :
        (bus.amount_user <= bus.amount_account);
    assign bus.newBalance = !bus.balance_update ? 10'd0 :
        (bus.deposite ? (bus.amount_account + bus.amount_user) : (bus.amount_account - bus.amount_user));

    // ---------------- expectation model ----------------
    typedef struct {
        bit         busy, done, acc, rej, re, we, dep, wd, bu, lck;
        logic [3:0] addr;
        logic [9:0] wdata, au, aa, bout;
        int         rej_after;
    } exp_t;

    exp_t       m_exp;
    exp_t       sched [$];
    int         m_rej;
    logic [9:0] m_mem [16];
    int         checks   = 0;
    int         failures = 0;
    bit         chk_en   = 1'b0;

    function automatic exp_t idle_vec(input bit lck);
        exp_t e;
        e.busy = 0; e.done = 0; e.acc = 0; e.rej = 0; e.re = 0; e.we = 0;
        e.dep = 0; e.wd = 0; e.bu = 0; e.lck = lck;
        e.addr = '0; e.wdata = '0; e.au = '0; e.aa = '0; e.bout = '0;
        e.rej_after = -1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected per-cycle outputs of one request, derived from the transaction timeline.
    task automatic launch(input bit dep, input bit wd, input logic [3:0] acct, input logic [9:0] amt);
        exp_t e;
        int   bal, nb, sat;
        bit   ok;
        sat = (m_rej < LIM) ? m_rej + 1 : LIM;
        if (dep == wd) begin
            e = idle_vec(0); e.busy = 1; e.done = 1; e.rej = 1; e.bout = '0;
            e.rej_after = sat; e.lck = (sat == LIM);
            sched.push_back(e);
            return;
        end
        bal = int'(m_mem[acct]);
        ok  = dep ? (bal + int'(amt) <= 1023) : (int'(amt) <= bal);
        nb  = dep ? bal + int'(amt) : bal - int'(amt);
        e = idle_vec(0); e.busy = 1; e.re = 1; e.addr = acct; sched.push_back(e);
        e = idle_vec(0); e.busy = 1; sched.push_back(e);
        e = idle_vec(0); e.busy = 1; e.dep = dep; e.wd = wd; e.au = amt; e.aa = 10'(bal);
        sched.push_back(e);
        if (ok) begin
            e.bu = 1; sched.push_back(e);
            e = idle_vec(0); e.busy = 1; e.we = 1; e.addr = acct; e.wdata = 10'(nb);
            sched.push_back(e);
            e = idle_vec(0); e.busy = 1; e.done = 1; e.acc = 1; e.bout = 10'(nb); e.rej_after = 0;
            sched.push_back(e);
        end else begin
            e = idle_vec(0); e.busy = 1; e.done = 1; e.rej = 1; e.bout = 10'(bal);
            e.rej_after = sat; e.lck = (sat == LIM);
            sched.push_back(e);
        end
    endtask

    // Advance the model by one clock using the inputs just applied.
    task automatic model_step();
        exp_t cur;
        cur = m_exp;
        if (rst) begin
            sched.delete();
            m_rej = 0;
            m_exp = idle_vec(0);
            return;
        end
        if (cur.we) m_mem[cur.addr] = cur.wdata;
        if (!cur.busy && sched.size() == 0) begin
            if (bus.session_end) m_rej = 0;
            else if (bus.start && m_rej != LIM)
                launch(bus.op_deposit, bus.op_withdraw, bus.acct_id, bus.amount_in);
        end
        if (sched.size() > 0) begin
            m_exp = sched.pop_front();
            if (m_exp.done) m_rej = m_exp.rej_after;
        end else begin
            m_exp = idle_vec(m_rej == LIM);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ctrl", {22'd0, bus.busy, bus.done, bus.accepted, bus.rejected, bus.mem_re,
                         bus.mem_we, bus.deposite, bus.withdraw, bus.balance_update, bus.locked},
                        {22'd0, m_exp.busy, m_exp.done, m_exp.acc, m_exp.rej, m_exp.re,
                         m_exp.we, m_exp.dep, m_exp.wd, m_exp.bu, m_exp.lck});
            if (m_exp.re || m_exp.we) chk("mem_addr", 32'(bus.mem_addr), 32'(m_exp.addr));
            if (m_exp.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_exp.wdata));
            if (m_exp.dep || m_exp.wd) begin
                chk("amount_user", 32'(bus.amount_user), 32'(m_exp.au));
                chk("amount_account", 32'(bus.amount_account), 32'(m_exp.aa));
            end
            if (m_exp.done) chk("balance_out", 32'(bus.balance_out), 32'(m_exp.bout));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply(input bit st, input bit dep, input bit wd, input int acct,
                         input int amt, input bit se, input bit r);
        bus.start       = st;
        bus.op_deposit  = dep;
        bus.op_withdraw = wd;
        bus.acct_id     = 4'(acct);
        bus.amount_in   = 10'(amt);
        bus.session_end = se;
        rst             = r;
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycle();
        apply(0, 0, 0, 0, 0, 0, 0);
        adv();
    endtask

    // One request; reports latency to done and the done-cycle status.
    task automatic run_txn(input bit dep, input bit wd, input int acct, input int amt,
                           output int lat, output bit acc, output bit rej,
                           output int bout, output bit lck, output bit we_seen);
        lat = 0; acc = 0; rej = 0; bout = -1; lck = 0; we_seen = 0;
        apply(1, dep, wd, acct, amt, 0, 0);
        adv();
        lat = 1;
        while (!bus.done && lat < 12) begin
            if (bus.mem_we) we_seen = 1;
            apply(0, 0, 0, 0, 0, 0, 0);
            adv();
            lat++;
        end
        if (bus.done) begin
            acc = bus.accepted; rej = bus.rejected; bout = int'(bus.balance_out); lck = bus.locked;
        end else begin
            checks++; failures++;
            $display("FAIL txn_timeout: no done within %0d cycles", lat);
        end
        idle_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat, bout;
        bit acc, rej, lck, we_seen, any_resp;
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        m_rej = 0;
        m_exp = idle_vec(0);
        chk_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 1); adv();
        apply(0, 0, 0, 0, 0, 0, 1); adv();
        preload = 1'b0;
        idle_cycle();

        // reset state
        chk("reset_ctrl", {bus.busy, bus.done, bus.accepted, bus.rejected, bus.mem_re, bus.mem_we,
                           bus.deposite, bus.withdraw, bus.balance_update, bus.locked}, 0);
        chk("reset_bus", {bus.mem_addr, bus.mem_wdata, bus.amount_user, bus.amount_account,
                          bus.balance_out}, 0);

        // deposit 100 to 200
        run_txn(1, 0, 0, 100, lat, acc, rej, bout, lck, we_seen);
        chk("dep100_lat", lat, 6);
        chk("dep100_acc", {acc, rej}, 2'b10);
        chk("dep100_bal", bout, 300);
        chk("dep100_mem", env_mem[0], 300);

        // withdraw 250 from 200, then 5 from 0
        run_txn(0, 1, 4, 250, lat, acc, rej, bout, lck, we_seen);
        chk("wd250_lat", lat, 4);
        chk("wd250_rej", {acc, rej, we_seen}, 3'b010);
        chk("wd250_bal", bout, 200);
        run_txn(0, 1, 1, 5, lat, acc, rej, bout, lck, we_seen);
        chk("wd5_lat", lat, 4);
        chk("wd5_rej", {acc, rej, we_seen, lck}, 4'b0100);
        chk("wd5_bal", bout, 0);

        // two rejects then accept: deposit 23 to 1000
        run_txn(1, 0, 2, 23, lat, acc, rej, bout, lck, we_seen);
        chk("dep23_acc", {acc, rej}, 2'b10);
        chk("dep23_bal", bout, 1023);
        chk("dep23_mem", env_mem[2], 1023);

        // overflow, illegal op, then the third reject locks
        run_txn(1, 0, 5, 24, lat, acc, rej, bout, lck, we_seen);
        chk("dep24_rej", {acc, rej, lck}, 3'b010);
        chk("dep24_bal", bout, 1000);
        run_txn(1, 1, 0, 10, lat, acc, rej, bout, lck, we_seen);
        chk("both_lat", lat, 1);
        chk("both_rej", {acc, rej, lck}, 3'b010);
        chk("both_bal", bout, 0);
        run_txn(0, 1, 1, 999, lat, acc, rej, bout, lck, we_seen);
        chk("third_rej_lock", {acc, rej, lck}, 3'b011);

        // start while locked gets no response
        any_resp = 0;
        apply(1, 1, 0, 0, 10, 0, 0);
        for (int i = 0; i < 8; i++) begin
            adv();
            if (bus.busy || bus.done) any_resp = 1;
            apply(0, 0, 0, 0, 0, 0, 0);
        end
        adv();
        chk("locked_ignore", any_resp, 0);
        chk("still_locked", bus.locked, 1);

        // session_end together with start: unlock, start dropped
        apply(1, 1, 0, 0, 10, 1, 0); adv();
        chk("session_unlock", {bus.locked, bus.busy}, 2'b00);
        idle_cycle();
        run_txn(1, 0, 3, 10, lat, acc, rej, bout, lck, we_seen);
        chk("after_unlock", {acc, rej}, 2'b10);
        chk("after_unlock_bal", bout, 510);

        // reset in COMMIT
        apply(1, 1, 0, 3, 7, 0, 0); adv();
        repeat (3) idle_cycle();
        chk("commit_bu", bus.balance_update, 1);
        apply(0, 0, 0, 0, 0, 0, 1); adv();
        chk("rst_commit_out", {bus.busy, bus.mem_we, bus.balance_update, bus.done, bus.deposite}, 0);
        idle_cycle();
        chk("rst_commit_mem", env_mem[3], 510);

        // reset on the WRITE cycle
        apply(1, 1, 0, 3, 7, 0, 0); adv();
        repeat (4) idle_cycle();
        chk("write_we", bus.mem_we, 1);
        apply(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("rst_write_we", bus.mem_we, 0);
        adv();
        idle_cycle();
        chk("rst_write_mem", env_mem[3], 510);

        // normal transaction after resets
        run_txn(1, 0, 3, 7, lat, acc, rej, bout, lck, we_seen);
        chk("post_rst_acc", {acc, rej}, 2'b10);
        chk("post_rst_bal", bout, 517);

        // random traffic, including held start, session ends and resets
        for (int i = 0; i < 2500; i++) begin
            int  sel, acct, amt, am;
            bit  dep, wd;
            sel  = int'($urandom_range(0, 9));
            dep  = (sel == 1) || (sel >= 2 && sel <= 5);
            wd   = (sel == 1) || (sel >= 6);
            acct = int'($urandom_range(0, 7));
            am   = int'($urandom_range(0, 3));
            case (am)
                0: amt = int'($urandom_range(0, 1023));
                1: amt = int'($urandom_range(0, 63));
                2: amt = int'(m_mem[acct]) + int'($urandom_range(0, 1));
                default: amt = 1023 - int'(m_mem[acct]) + int'($urandom_range(0, 1));
            endcase
            apply($urandom_range(0, 2) != 0, dep, wd, acct, amt & 1023,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
            adv();
        end
        repeat (8) idle_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
